wptr_full: RTL
==============

// Module: wptr_full
// PURPOSE
// - Write-domain pointer/flag controller of the async FIFO; mirror of the read-side pointer/empty block.
// - Keeps the binary write pointer, drives the Gray write pointer across to the read domain, and
//   produces registered full, almost-full and fill-level flags.
// - Input is the read pointer already double-synced into wclk (wq2_rptr).
// - waddr addresses the dual-port FIFO memory write port.
// PARAMETERS
// - ADDRSIZE     4   memory address bits; depth = 2**ADDRSIZE; legal range >= 2
// - AFULL_THRESH 12  walmost_full asserts when fill level >= this; legal 1..2**ADDRSIZE
// PORTS
// - wclk          in   1           write-domain clock
// - wrst_n        in   1           async active-low reset, write domain
// - winc          in   1           write request (one word per cycle)
// - wovf_clr      in   1           clears sticky woverflow (feature macro only)
// - wq2_rptr      in   ADDRSIZE+1  Gray read pointer, synced to wclk
// - wptr          out  ADDRSIZE+1  registered Gray write pointer, to read-side sync
// - waddr         out  ADDRSIZE    memory write address = wbin[ADDRSIZE-1:0]
// - wfull         out  1           registered full flag
// - walmost_full  out  1           registered almost-full flag
// - wcount        out  ADDRSIZE+1  registered fill level as seen from write domain, 0..2**ADDRSIZE
// - woverflow     out  1           sticky write-while-full flag (feature macro only)
// BEHAVIOUR
// - Reset (async assert, sync release): wbin=0, wptr=0, wfull=0, walmost_full=0, wcount=0, woverflow=0.
// - Accepted write: wpush = winc & ~wfull. winc while wfull is dropped; pointer unchanged.
// - wbinnext = wbin + wpush, modulo 2**(ADDRSIZE+1); wgraynext = (wbinnext>>1) ^ wbinnext.
// - Each wclk edge: wbin<=wbinnext, wptr<=wgraynext. waddr is combinational from wbin, so the write
//   accepted in cycle N goes to waddr(N); the pointer advances at the end of cycle N.
// - Full: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
//   Flags describe the state after this cycle's write: 1-cycle latency, no comb path winc->wfull.
// - Fill level: rbin_s = Gray-to-binary(wq2_rptr) (XOR prefix from MSB).
//   wcount <= wbinnext - rbin_s, ADDRSIZE+1 bits, modulo arithmetic, so pointer wrap is transparent.
//   wcount == 2**ADDRSIZE exactly when wfull is set next cycle.
// - Almost full: walmost_full <= (wbinnext - rbin_s) >= AFULL_THRESH. Same edge as wcount.
// - Pessimism: wq2_rptr lags by 2+ cycles; wfull/wcount may overstate occupancy and never understate it.
//   wfull clears at most 1 cycle after wq2_rptr moves.
// - Simultaneous write and read-pointer advance in one cycle: both are applied; level unchanged.
//   When full, a read frees a slot and wfull deasserts; a write in that same cycle is still dropped,
//   because it is gated by the registered wfull.
// - wq2_rptr changes by at most one Gray bit per cycle; the bench must respect this.
// - No other state machine: the counter plus registered flags are the whole of the state.
// CONFIGURATION
// - Macro WPTR_FULL_OVERFLOW_EN
//   - Defined: woverflow sets on the cycle after any winc & wfull and holds until wovf_clr=1 (one cycle)
//     or reset.
//   - Set and clear in the same cycle: set wins.
//   - Not defined: woverflow tied 0, wovf_clr ignored, no flop inferred.
// TESTING (ADDRSIZE=4, AFULL_THRESH=12)
// - Reset mid-stream: after 5 writes, pulse wrst_n low
//   -> all outputs 0 asynchronously; first write after release goes to waddr=0.
// - Fill from empty: wq2_rptr=0, 16 consecutive winc
//   -> wcount steps 1..16; walmost_full rises after write 12; wfull rises after write 16;
//   -> wptr ends 5'b11000 (Gray of 16).
// - Write while full: 3 extra winc
//   -> wptr/waddr/wcount unchanged (16);
//   -> with WPTR_FULL_OVERFLOW_EN woverflow=1 and stays 1 until wovf_clr, then 0; without it, stays 0.
// - Drain and simultaneity: while full, step wq2_rptr 0->1 (Gray) with winc held
//   -> wfull falls next cycle and that cycle's write is dropped;
//   -> following write accepted, wcount back to 16, wfull=1.
// - Wrap-around: run 40 writes against a tracking read pointer kept 3 behind
//   -> wcount stays 3 through binary wrap 31->0; wfull never asserts; Gray wptr changes one bit per step.
// - Threshold edge: hold level at 11, write once
//   -> walmost_full 0->1 on that edge; lower level to 11 via wq2_rptr -> walmost_full 1->0 next cycle.

Source files
------------

// File: rtl/wptr_full.sv
// Write-side pointer and flag block of an async FIFO: binary/Gray write pointer, full, almost-full, fill level.
// Optional sticky write-while-full flag is built only when WPTR_FULL_OVERFLOW_EN is defined.
module wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic                wovf_clr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] LP_AFULL = AFULL_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr;
    logic              r_wfull;
    logic              r_walmost_full;
    logic [ADDRSIZE:0] r_wcount;

    logic              w_wpush;
    logic [ADDRSIZE:0] w_wbinnext;
    logic [ADDRSIZE:0] w_wgraynext;
    logic [ADDRSIZE:0] w_rbin_s;
    logic [ADDRSIZE:0] w_level;
    logic [ADDRSIZE:0] w_full_match;
    logic              w_wfull_next;
    logic              w_walmost_next;

    // Writes are gated by the registered full flag, so a write coinciding with a freeing read is dropped.
    assign w_wpush     = winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_wpush};
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
        assign w_rbin_s[gi] = ^(wq2_rptr >> gi);
    end

    assign w_level        = w_wbinnext - w_rbin_s;
    assign w_full_match   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign w_wfull_next   = (w_wgraynext == w_full_match);
    assign w_walmost_next = (w_level >= LP_AFULL);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfull        <= w_wfull_next;
            r_walmost_full <= w_walmost_next;
            r_wcount       <= w_level;
        end
    end

`ifdef WPTR_FULL_OVERFLOW_EN
    logic r_woverflow;

    // A new overflow takes priority over a clear issued in the same cycle.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_woverflow <= 1'b0;
        end else if (winc & r_wfull) begin
            r_woverflow <= 1'b1;
        end else if (wovf_clr) begin
            r_woverflow <= 1'b0;
        end
    end

    assign woverflow = r_woverflow;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = wovf_clr;
    assign woverflow        = 1'b0;
`endif

    assign wptr         = r_wptr;
    assign waddr        = r_wbin[ADDRSIZE-1:0];
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wcount       = r_wcount;

endmodule
